// File: rtl/rca2_accum.sv
// Packet accumulator: sums per-beat 2-bit operand pairs (via a 2-bit ripple-carry
// adder) over up to 16 beats and presents total, beat count and carry flag.
module rca2_accum #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic [4:0]       count,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [2:0]       pair_s;
  logic [ACC_W:0]   add_s;
  logic             term_s;

  rca2 u_rca2 (
    .a   (a),
    .b   (b),
    .cin (1'b0),
    .out (pair_s)
  );

  assign add_s  = {1'b0, acc_q} + {{(ACC_W-2){1'b0}}, pair_s};
  // The 16th beat closes the packet even without last.
  assign term_s = last | (cnt_q == 5'd15);

  // Next-state and datapath update; a/b/last only matter on an accepted beat.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (in_valid) begin
          acc_d   = add_s[ACC_W-1:0];
          cnt_d   = cnt_q + 5'd1;
          ovf_d   = ovf_q | add_s[ACC_W];
          state_d = term_s ? S_DONE : S_ACC;
        end else begin
          state_d = state_q;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = 5'd0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = 5'd0;
        ovf_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= 5'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshakes are forced low for as long as reset is held.
  assign in_ready  = rst_n & (state_q != S_DONE);
  assign out_valid = rst_n & (state_q == S_DONE);
  assign sum       = acc_q;
  assign count     = cnt_q;
  assign ovf       = ovf_q;

endmodule

// Two-bit ripple-carry adder; out[2] is the carry-out.
module rca2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [2:0] out
);

  logic c1_s;

  assign out[0] = a[0] ^ b[0] ^ cin;
  assign c1_s   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
  assign out[1] = a[1] ^ b[1] ^ c1_s;
  assign out[2] = (a[1] & b[1]) | (c1_s & (a[1] ^ b[1]));

endmodule
